wb_arbiter: RTL and testbench

//  Writeback stage directly upstream of the register file: merges completed results from the

---
 rtl/wb_arbiter_if.sv | 45 ++++
 rtl/wb_arbiter.sv | 136 +++++++++++++
 tb/tb_wb_arbiter.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_if.sv
// Writeback bus bundle: ALU/memory result inputs, regfile write outputs and scoreboard lookup.
// The master modport is the upstream/decode side; the slave modport is the arbiter.
interface wb_arbiter_if #(
    parameter int FIFO_DEPTH = 4,
    parameter int XLEN       = 32
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            mem_valid;
    logic            mem_ready;
    logic [4:0]      mem_rd;
    logic [XLEN-1:0] mem_data;
    logic            w_enable;
    logic [4:0]      w_addr;
    logic [XLEN-1:0] w_data;
    logic [CW-1:0]   fifo_count;
    logic [31:0]     retired;
    logic            issue_valid;
    logic [4:0]      issue_rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            busy_rs1;
    logic            busy_rs2;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output mem_valid, mem_rd, mem_data,
        input  mem_ready,
        input  w_enable, w_addr, w_data, fifo_count, retired,
        output issue_valid, issue_rd, rs1, rs2,
        input  busy_rs1, busy_rs2
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  mem_valid, mem_rd, mem_data,
        output mem_ready,
        output w_enable, w_addr, w_data, fifo_count, retired,
        input  issue_valid, issue_rd, rs1, rs2,
        output busy_rs1, busy_rs2
    );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU results first, then in-order memory FIFO, else memory bypass, onto one regfile port.
// Latency: 1 cycle to registered w_*; memory results 1 cycle via bypass, else 1 + queue depth.
// Backpressure: ALU never stalls; mem_ready = !fifo_full. Optional WB_SCOREBOARD_EN adds the busy bitmap.
module wb_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int XLEN       = 32
) (
    input  logic           clk,
    input  logic           rstn,
    wb_arbiter_if.slave    bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [4:0]      r_fifo_rd   [FIFO_DEPTH];
    logic [XLEN-1:0] r_fifo_data [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    logic            r_w_enable;
    logic [4:0]      r_w_addr;
    logic [XLEN-1:0] r_w_data;
    logic [31:0]     r_retired;

    logic            w_full;
    logic            w_empty;
    logic            w_mem_acc;
    logic            w_alu_wr;
    logic            w_pop;
    logic            w_bypass;
    logic            w_push;
    logic            w_wr_en;
    logic [4:0]      w_wr_rd;
    logic [XLEN-1:0] w_wr_data;

    // A full FIFO refuses even when popping, so ready never depends on the select.
    assign w_full    = (r_count == CW'(FIFO_DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_mem_acc = bus.mem_valid & ~w_full;
    assign w_alu_wr  = bus.alu_valid & (bus.alu_rd != 5'd0);
    assign w_pop     = ~w_alu_wr & ~w_empty;
    assign w_bypass  = ~w_alu_wr & w_empty & w_mem_acc & (bus.mem_rd != 5'd0);
    assign w_push    = w_mem_acc & (bus.mem_rd != 5'd0) & ~w_bypass;

    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_rd   = 5'd0;
        w_wr_data = '0;
        if (w_alu_wr) begin
            w_wr_en   = 1'b1;
            w_wr_rd   = bus.alu_rd;
            w_wr_data = bus.alu_data;
        end else if (w_pop) begin
            w_wr_en   = 1'b1;
            w_wr_rd   = r_fifo_rd[r_rd_ptr];
            w_wr_data = r_fifo_data[r_rd_ptr];
        end else if (w_bypass) begin
            w_wr_en   = 1'b1;
            w_wr_rd   = bus.mem_rd;
            w_wr_data = bus.mem_data;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_rd[r_wr_ptr]   <= bus.mem_rd;
            r_fifo_data[r_wr_ptr] <= bus.mem_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_w_enable <= 1'b0;
            r_w_addr   <= 5'd0;
            r_w_data   <= '0;
            r_retired  <= 32'd0;
        end else begin
            r_w_enable <= w_wr_en;
            if (w_wr_en) begin
                r_w_addr  <= w_wr_rd;
                r_w_data  <= w_wr_data;
                r_retired <= r_retired + 32'd1;
            end
        end
    end

    assign bus.mem_ready  = ~w_full;
    assign bus.w_enable   = r_w_enable;
    assign bus.w_addr     = r_w_addr;
    assign bus.w_data     = r_w_data;
    assign bus.fifo_count = r_count;
    assign bus.retired    = r_retired;

`ifdef WB_SCOREBOARD_EN
    logic [31:0] r_busy;
    logic [31:0] w_busy_set;
    logic [31:0] w_busy_clr;
    logic [31:0] w_busy_nxt;

    // Set is applied after clear so a same-cycle issue to the retiring rd stays busy.
    always_comb begin
        w_busy_set = '0;
        w_busy_clr = '0;
        if (bus.issue_valid && (bus.issue_rd != 5'd0)) w_busy_set[bus.issue_rd] = 1'b1;
        if (w_wr_en) w_busy_clr[w_wr_rd] = 1'b1;
        w_busy_nxt    = (r_busy & ~w_busy_clr) | w_busy_set;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rstn) r_busy <= '0;
        else       r_busy <= w_busy_nxt;
    end

    assign bus.busy_rs1 = r_busy[bus.rs1];
    assign bus.busy_rs2 = r_busy[bus.rs2];
`else
    logic w_sb_unused;
    assign w_sb_unused  = ^{bus.issue_valid, bus.issue_rd, bus.rs1, bus.rs2};
    assign bus.busy_rs1 = 1'b0;
    assign bus.busy_rs2 = 1'b0;
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, ALU write, bypass, FIFO ordering/backpressure, rd==0 drop,
// mid-run reset and (when WB_SCOREBOARD_EN is defined) the busy bitmap.
module tb_wb_arbiter;
    logic clk;
    logic rstn;
    int   n_tests;
    int   n_fail;

    wb_arbiter_if #(.FIFO_DEPTH(4), .XLEN(32)) bus ();

    wb_arbiter #(.FIFO_DEPTH(4), .XLEN(32)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.alu_valid   = 1'b0;
        bus.alu_rd      = 5'd0;
        bus.alu_data    = 32'd0;
        bus.mem_valid   = 1'b0;
        bus.mem_rd      = 5'd0;
        bus.mem_data    = 32'd0;
        bus.issue_valid = 1'b0;
        bus.issue_rd    = 5'd0;
        bus.rs1         = 5'd0;
        bus.rs2         = 5'd0;
    endtask

    task automatic test_reset;
        idle_inputs();
        rstn = 1'b0;
        tick();
        tick();
        n_tests++; if (bus.w_enable !== 1'b0) begin n_fail++; $display("FAIL reset_w_enable: got %b expected 0", bus.w_enable); end
        n_tests++; if (bus.w_addr !== 5'd0) begin n_fail++; $display("FAIL reset_w_addr: got %0d expected 0", bus.w_addr); end
        n_tests++; if (bus.w_data !== 32'd0) begin n_fail++; $display("FAIL reset_w_data: got %h expected 0", bus.w_data); end
        n_tests++; if (bus.fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_fifo_count: got %0d expected 0", bus.fifo_count); end
        n_tests++; if (bus.retired !== 32'd0) begin n_fail++; $display("FAIL reset_retired: got %0d expected 0", bus.retired); end
        n_tests++; if (bus.mem_ready !== 1'b1) begin n_fail++; $display("FAIL reset_mem_ready: got %b expected 1", bus.mem_ready); end
        rstn = 1'b1;
    endtask

    task automatic test_alu_write;
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd5;
        bus.alu_data  = 32'hDEADBEEF;
        tick();
        bus.alu_valid = 1'b0;
        n_tests++; if (bus.w_enable !== 1'b1) begin n_fail++; $display("FAIL alu_w_enable: got %b expected 1", bus.w_enable); end
        n_tests++; if (bus.w_addr !== 5'd5) begin n_fail++; $display("FAIL alu_w_addr: got %0d expected 5", bus.w_addr); end
        n_tests++; if (bus.w_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL alu_w_data: got %h expected deadbeef", bus.w_data); end
        n_tests++; if (bus.retired !== 32'd1) begin n_fail++; $display("FAIL alu_retired: got %0d expected 1", bus.retired); end
        tick();
        n_tests++; if (bus.w_enable !== 1'b0) begin n_fail++; $display("FAIL alu_strobe_one_cycle: got %b expected 0", bus.w_enable); end
        n_tests++; if (bus.w_addr !== 5'd5 || bus.w_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL alu_hold: got %0d/%h expected 5/deadbeef", bus.w_addr, bus.w_data); end
    endtask

    task automatic test_bypass;
        bus.mem_valid = 1'b1;
        bus.mem_rd    = 5'd7;
        bus.mem_data  = 32'h11;
        n_tests++; if (bus.mem_ready !== 1'b1) begin n_fail++; $display("FAIL bypass_ready: got %b expected 1", bus.mem_ready); end
        tick();
        bus.mem_valid = 1'b0;
        n_tests++; if (bus.w_enable !== 1'b1 || bus.w_addr !== 5'd7 || bus.w_data !== 32'h11) begin
            n_fail++; $display("FAIL bypass_write: got en=%b addr=%0d data=%h expected en=1 addr=7 data=11", bus.w_enable, bus.w_addr, bus.w_data);
        end
        n_tests++; if (bus.fifo_count !== 3'd0) begin n_fail++; $display("FAIL bypass_fifo_count: got %0d expected 0", bus.fifo_count); end
        n_tests++; if (bus.retired !== 32'd2) begin n_fail++; $display("FAIL bypass_retired: got %0d expected 2", bus.retired); end
        tick();
    endtask

    task automatic test_fifo_order;
        logic       exp_rdy_fill [6];
        logic [4:0] exp_addr [5];
        logic [2:0] exp_cnt  [5];
        logic       exp_rdy_drain [2];
        logic [4:0] next_rd;
        logic       acc;
        logic [31:0] exp_data;
        exp_rdy_fill  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        exp_addr      = '{5'd2, 5'd3, 5'd4, 5'd5, 5'd6};
        exp_cnt       = '{3'd3, 3'd3, 3'd2, 3'd1, 3'd0};
        exp_rdy_drain = '{1'b0, 1'b1};
        next_rd = 5'd2;
        for (int c = 0; c < 6; c++) begin
            bus.alu_valid = 1'b1;
            bus.alu_rd    = 5'd1;
            bus.alu_data  = 32'hA000_0000 + c;
            bus.mem_valid = 1'b1;
            bus.mem_rd    = next_rd;
            bus.mem_data  = 32'h100 + {27'd0, next_rd};
            n_tests++; if (bus.mem_ready !== exp_rdy_fill[c]) begin n_fail++; $display("FAIL fill_ready[%0d]: got %b expected %b", c, bus.mem_ready, exp_rdy_fill[c]); end
            acc = bus.mem_ready;
            tick();
            if (acc) next_rd = next_rd + 5'd1;
            n_tests++; if (bus.w_enable !== 1'b1 || bus.w_addr !== 5'd1) begin n_fail++; $display("FAIL fill_alu_write[%0d]: got en=%b addr=%0d expected en=1 addr=1", c, bus.w_enable, bus.w_addr); end
        end
        n_tests++; if (bus.fifo_count !== 3'd4) begin n_fail++; $display("FAIL fill_count: got %0d expected 4", bus.fifo_count); end
        bus.alu_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k < 2) begin
                bus.mem_valid = 1'b1;
                bus.mem_rd    = next_rd;
                bus.mem_data  = 32'h100 + {27'd0, next_rd};
                n_tests++; if (bus.mem_ready !== exp_rdy_drain[k]) begin n_fail++; $display("FAIL drain_ready[%0d]: got %b expected %b", k, bus.mem_ready, exp_rdy_drain[k]); end
                acc = bus.mem_ready;
            end else begin
                bus.mem_valid = 1'b0;
                acc = 1'b0;
            end
            tick();
            if (acc) next_rd = next_rd + 5'd1;
            exp_data = 32'h100 + {27'd0, exp_addr[k]};
            n_tests++; if (bus.w_enable !== 1'b1 || bus.w_addr !== exp_addr[k] || bus.w_data !== exp_data) begin
                n_fail++; $display("FAIL drain_write[%0d]: got en=%b addr=%0d data=%h expected en=1 addr=%0d data=%h", k, bus.w_enable, bus.w_addr, bus.w_data, exp_addr[k], exp_data);
            end
            n_tests++; if (bus.fifo_count !== exp_cnt[k]) begin n_fail++; $display("FAIL drain_count[%0d]: got %0d expected %0d", k, bus.fifo_count, exp_cnt[k]); end
        end
        n_tests++; if (bus.retired !== 32'd13) begin n_fail++; $display("FAIL fifo_retired: got %0d expected 13", bus.retired); end
        tick();
        n_tests++; if (bus.w_enable !== 1'b0) begin n_fail++; $display("FAIL fifo_idle: got %b expected 0", bus.w_enable); end
    endtask

    task automatic test_rd_zero;
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd0;
        bus.alu_data  = 32'hBAD0BAD0;
        bus.mem_valid = 1'b1;
        bus.mem_rd    = 5'd9;
        bus.mem_data  = 32'h99;
        tick();
        bus.alu_valid = 1'b0;
        n_tests++; if (bus.w_enable !== 1'b1 || bus.w_addr !== 5'd9 || bus.w_data !== 32'h99) begin
            n_fail++; $display("FAIL rd0_alu_mem: got en=%b addr=%0d data=%h expected en=1 addr=9 data=99", bus.w_enable, bus.w_addr, bus.w_data);
        end
        n_tests++; if (bus.retired !== 32'd14) begin n_fail++; $display("FAIL rd0_retired: got %0d expected 14", bus.retired); end
        bus.mem_rd   = 5'd0;
        bus.mem_data = 32'h55;
        n_tests++; if (bus.mem_ready !== 1'b1) begin n_fail++; $display("FAIL rd0_mem_ready: got %b expected 1", bus.mem_ready); end
        tick();
        bus.mem_valid = 1'b0;
        n_tests++; if (bus.w_enable !== 1'b0 || bus.fifo_count !== 3'd0 || bus.retired !== 32'd14) begin
            n_fail++; $display("FAIL rd0_mem_drop: got en=%b cnt=%0d ret=%0d expected en=0 cnt=0 ret=14", bus.w_enable, bus.fifo_count, bus.retired);
        end
        n_tests++; if (bus.w_addr !== 5'd9) begin n_fail++; $display("FAIL rd0_hold_addr: got %0d expected 9", bus.w_addr); end
    endtask

    task automatic test_mid_reset;
        for (int c = 0; c < 3; c++) begin
            bus.alu_valid = 1'b1;
            bus.alu_rd    = 5'd1;
            bus.alu_data  = 32'h77;
            bus.mem_valid = 1'b1;
            bus.mem_rd    = 5'd10 + 5'(c);
            bus.mem_data  = 32'h200 + c;
            tick();
        end
        n_tests++; if (bus.fifo_count !== 3'd3) begin n_fail++; $display("FAIL mreset_fill: got %0d expected 3", bus.fifo_count); end
        idle_inputs();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        n_tests++; if (bus.fifo_count !== 3'd0 || bus.w_enable !== 1'b0 || bus.retired !== 32'd0 || bus.mem_ready !== 1'b1) begin
            n_fail++; $display("FAIL mreset_state: got cnt=%0d en=%b ret=%0d rdy=%b expected cnt=0 en=0 ret=0 rdy=1", bus.fifo_count, bus.w_enable, bus.retired, bus.mem_ready);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            n_tests++; if (bus.w_enable !== 1'b0 || bus.fifo_count !== 3'd0 || bus.retired !== 32'd0) begin
                n_fail++; $display("FAIL mreset_no_stale[%0d]: got en=%b cnt=%0d ret=%0d expected 0/0/0", c, bus.w_enable, bus.fifo_count, bus.retired);
            end
        end
    endtask

    task automatic test_scoreboard;
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd3;
        bus.rs1         = 5'd3;
        bus.rs2         = 5'd4;
        n_tests++; if (bus.busy_rs1 !== 1'b0) begin n_fail++; $display("FAIL sb_initial: got %b expected 0", bus.busy_rs1); end
        tick();
        bus.issue_valid = 1'b0;
`ifdef WB_SCOREBOARD_EN
        n_tests++; if (bus.busy_rs1 !== 1'b1 || bus.busy_rs2 !== 1'b0) begin n_fail++; $display("FAIL sb_set: got rs1=%b rs2=%b expected 1/0", bus.busy_rs1, bus.busy_rs2); end
        bus.alu_valid   = 1'b1;
        bus.alu_rd      = 5'd3;
        bus.alu_data    = 32'h33;
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd3;
        tick();
        bus.issue_valid = 1'b0;
        n_tests++; if (bus.w_enable !== 1'b1 || bus.busy_rs1 !== 1'b1) begin n_fail++; $display("FAIL sb_set_wins: got en=%b busy=%b expected 1/1", bus.w_enable, bus.busy_rs1); end
        tick();
        bus.alu_valid = 1'b0;
        n_tests++; if (bus.busy_rs1 !== 1'b0) begin n_fail++; $display("FAIL sb_clear: got %b expected 0", bus.busy_rs1); end
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd0;
        bus.rs1         = 5'd0;
        tick();
        bus.issue_valid = 1'b0;
        n_tests++; if (bus.busy_rs1 !== 1'b0) begin n_fail++; $display("FAIL sb_x0: got %b expected 0", bus.busy_rs1); end
`else
        n_tests++; if (bus.busy_rs1 !== 1'b0 || bus.busy_rs2 !== 1'b0) begin n_fail++; $display("FAIL sb_disabled: got rs1=%b rs2=%b expected 0/0", bus.busy_rs1, bus.busy_rs2); end
`endif
        idle_inputs();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rstn    = 1'b0;
        idle_inputs();
        test_reset();
        test_alu_write();
        test_bypass();
        test_fifo_order();
        test_rd_zero();
        test_mid_reset();
        test_scoreboard();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
